core_fru: RTL
=============

// Module: core_fru
// PURPOSE
//  Forwarding-resolution unit; drives sel_a/sel_b of core_oprandmux and the ID-stage stall.
//  Tracks in-flight destination registers through EX/MEM/WB in a 3-entry scoreboard.
//  A source produced by the WB-stage instruction selects wb_data. A source still in EX or MEM stalls ID.
//  Sits in core between the decoder and core_oprandmux.
// PARAMETERS
//  REG_AW  5   register index width (32 GPRs, r0 hardwired zero)
//  CNT_W   16  width of stall performance counter
// PORTS
//  clk          in   1       core clock
//  rst          in   1       asynchronous, active-high reset
//  id_valid     in   1       valid instruction in ID
//  id_rs_a      in   REG_AW  source reg for operand A
//  id_use_a     in   1       operand A reads id_rs_a
//  id_a_pc      in   1       operand A is PC (overrides id_use_a)
//  id_rs_b      in   REG_AW  source reg for operand B
//  id_b_src     in   2       0=reg rs_b, 1=PC, 2=imm, 3=none
//  id_rd        in   REG_AW  destination reg
//  id_wr        in   1       instruction writes id_rd
//  flush        in   1       pipeline flush (branch/exception)
//  cnt_clr      in   1       clear stall counter
//  sel_a        out  2       CORE_OPMUX_A_* code
//  sel_b        out  2       CORE_OPMUX_B_* code
//  stall        out  1       hold ID/IF this cycle
//  issue        out  1       ID instruction advances to EX this cycle
//  stall_cnt    out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  Scoreboard sb[0]=EX, sb[1]=MEM, sb[2]=WB; each entry {v, rd}. It shifts every clk:
//  sb[2]<=sb[1]; sb[1]<=sb[0]; sb[0]<={issue & id_wr & (id_rd!=0), id_rd}.
//  Bubble: v=0, inserted whenever issue=0.
//  Operand X "needs" reg r when (A: id_use_a & ~id_a_pc; B: id_b_src==0) and r!=0.
//  Match in sb[0] or sb[1] (v=1, rd==r) -> hazard. Hazard takes priority over any sb[2] match.
//  stall = id_valid & ~flush & (hazard_a | hazard_b); issue = id_valid & ~flush & ~stall.
//  sel_a: id_a_pc -> A_PC. Else WB match (no hazard) -> A_WB. Else A_RA.
//  sel_b: b_src 1 -> B_PC; b_src 2 -> B_IMM; b_src 3 -> B_RB. Else WB match -> B_WB, otherwise B_RB.
//  sel_*, stall and issue are combinational from ID inputs and registered sb.
//  Zero added latency: the mux samples sel on the same edge that moves the instruction to EX.
//  A stall on a MEM-stage producer lasts 1 cycle; on an EX-stage producer, 2 cycles.
//  The instruction then issues with sel=WB.
//  flush: clears all three sb entries at the next edge (wins over shift).
//  flush also forces stall=0 and issue=0 in the current cycle.
//  Simultaneous A and B hazards on different producers: stall until both clear, no partial issue.
//  rst (async): all sb.v=0, stall_cnt=0.
//  With sb empty, outputs are sel_a=A_RA, sel_b=B_RB, stall=0, issue=id_valid.
//  Reset mid-stall discards all tracked producers.
//  stall_cnt: +1 per cycle with stall=1, saturates at all-ones.
//  cnt_clr has priority over increment and zeroes the counter.
//  FSM (informational, derived from sb): RUN -> STALL on hazard. STALL -> RUN when hazard clears or on flush.
//  Expose fsm as internal reg for debug.
// STRUCTURE
//  CORE_OPMUX_A_RA=0, A_PC=1, A_WB=2, B_RB=0, B_PC=1, B_IMM=2, B_WB=3.
//  These codes and the id_b_src codes live in i2d_core_defines.v, shared with core_oprandmux.
//  One sub-module, core_fru_match: compares one source against 3 sb entries.
//  core_fru_match outputs {hazard, wb_hit}; instantiate twice, for A and B.
// TESTING
//  1. rst=1 then release, id_valid=1, rs_a=3, rs_b=4 -> sel_a=0, sel_b=0, stall=0, issue=1, stall_cnt=0.
//  2. Issue rd=5; next cycle read rs_a=5 -> stall 2 cycles, then sel_a=A_WB(2), issue=1.
//     stall_cnt increments 0 -> 2.
//  3. Issue rd=6, one unrelated instr, then rs_b=6 with b_src=0 -> 1 stall, then sel_b=B_WB(3).
//     With b_src=2 and the same rs_b=6 -> sel_b=B_IMM(2), no stall.
//  4. Write r0, then read r0 on both operands -> no stall, sel_a=A_RA, sel_b=B_RB.
//  5. Hazard stall in progress, flush=1 one cycle -> stall=0, issue=0.
//     Next cycle same reads resolve with sb empty -> sel_a=A_RA, no stall.
//  6. stall_cnt preloaded near saturation (CNT_W=4 build): 20 stall cycles -> holds 15.
//     cnt_clr while stalling -> 0.

Source files
------------

// File: rtl/core_fru_pkg.sv
// core_fru_pkg: shared encodings for the forwarding-resolution unit.
//   - operand-mux select codes consumed by core_oprandmux
//   - operand-B source codes produced by the decoder
//   - informational FSM state type
package core_fru_pkg;

  // Operand A mux select codes
  localparam logic [1:0] CORE_OPMUX_A_RA  = 2'd0;
  localparam logic [1:0] CORE_OPMUX_A_PC  = 2'd1;
  localparam logic [1:0] CORE_OPMUX_A_WB  = 2'd2;

  // Operand B mux select codes
  localparam logic [1:0] CORE_OPMUX_B_RB  = 2'd0;
  localparam logic [1:0] CORE_OPMUX_B_PC  = 2'd1;
  localparam logic [1:0] CORE_OPMUX_B_IMM = 2'd2;
  localparam logic [1:0] CORE_OPMUX_B_WB  = 2'd3;

  // Decoder operand-B source codes
  localparam logic [1:0] B_SRC_REG  = 2'd0;
  localparam logic [1:0] B_SRC_PC   = 2'd1;
  localparam logic [1:0] B_SRC_IMM  = 2'd2;
  localparam logic [1:0] B_SRC_NONE = 2'd3;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StStall = 1'b1
  } fru_state_e;

endpackage

// File: rtl/core_fru_if.sv
// core_fru_if: ID-stage request and forwarding-control response bundle.
//   master: decoder side (drives id_*, flush, cnt_clr; receives sel/stall/issue/count)
//   slave : core_fru side
interface core_fru_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs_a;
  logic              id_use_a;
  logic              id_a_pc;
  logic [REG_AW-1:0] id_rs_b;
  logic [1:0]        id_b_src;
  logic [REG_AW-1:0] id_rd;
  logic              id_wr;
  logic              flush;
  logic              cnt_clr;
  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic              stall;
  logic              issue;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs_a, id_use_a, id_a_pc, id_rs_b, id_b_src, id_rd, id_wr,
    output flush, cnt_clr,
    input  sel_a, sel_b, stall, issue, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_use_a, id_a_pc, id_rs_b, id_b_src, id_rd, id_wr,
    input  flush, cnt_clr,
    output sel_a, sel_b, stall, issue, stall_cnt
  );
endinterface

// File: rtl/core_fru_match.sv
// core_fru_match: compares one source register against the 3-entry scoreboard.
//   i_rs      source register index
//   i_need    operand actually reads i_rs
//   i_sb_v    entry valid bits, [0]=EX [1]=MEM [2]=WB
//   i_sb_rd   entry destination registers
//   o_hazard  producer still in EX or MEM
//   o_wb_hit  producer in WB and no hazard, forward wb_data
module core_fru_match #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0]      i_rs,
  input  logic                   i_need,
  input  logic [2:0]             i_sb_v,
  input  logic [2:0][REG_AW-1:0] i_sb_rd,
  output logic                   o_hazard,
  output logic                   o_wb_hit
);

  logic       w_req;
  logic [2:0] w_hit;

  // r0 is hardwired zero, so it never has a producer worth waiting for
  assign w_req = i_need && (i_rs != '0);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_hit[k] = i_sb_v[k] && (i_sb_rd[k] == i_rs);
    end
  end

  // A younger in-flight producer shadows an older WB one
  assign o_hazard = w_req & (w_hit[0] | w_hit[1]);
  assign o_wb_hit = w_req & w_hit[2] & ~o_hazard;

endmodule

// File: rtl/core_fru.sv
// core_fru: forwarding-resolution unit between the decoder and core_oprandmux.
//   clk, rst      core clock, asynchronous active-high reset
//   bus (slave)   ID request in; sel_a/sel_b/stall/issue/stall_cnt out
// Tracks in-flight destinations through EX/MEM/WB; WB producers are forwarded,
// EX/MEM producers stall ID. Outputs are combinational from ID inputs and the scoreboard.
module core_fru
  import core_fru_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  core_fru_if.slave    bus
);

  logic [2:0]             r_sb_v;
  logic [2:0][REG_AW-1:0] r_sb_rd;
  logic [CNT_W-1:0]       r_cnt;
  fru_state_e             r_fsm, w_fsm_d;

  logic w_need_a, w_need_b;
  logic w_haz_a, w_haz_b, w_wb_a, w_wb_b;
  logic w_stall, w_issue;

  assign w_need_a = bus.id_use_a & ~bus.id_a_pc;
  assign w_need_b = (bus.id_b_src == B_SRC_REG);

  core_fru_match #(.REG_AW(REG_AW)) u_match_a (
    .i_rs     (bus.id_rs_a),
    .i_need   (w_need_a),
    .i_sb_v   (r_sb_v),
    .i_sb_rd  (r_sb_rd),
    .o_hazard (w_haz_a),
    .o_wb_hit (w_wb_a)
  );

  core_fru_match #(.REG_AW(REG_AW)) u_match_b (
    .i_rs     (bus.id_rs_b),
    .i_need   (w_need_b),
    .i_sb_v   (r_sb_v),
    .i_sb_rd  (r_sb_rd),
    .o_hazard (w_haz_b),
    .o_wb_hit (w_wb_b)
  );

  // Either hazard holds the whole instruction; no partial issue
  assign w_stall = bus.id_valid & ~bus.flush & (w_haz_a | w_haz_b);
  assign w_issue = bus.id_valid & ~bus.flush & ~w_stall;

  always_comb begin
    bus.sel_a = CORE_OPMUX_A_RA;
    if (bus.id_a_pc)  bus.sel_a = CORE_OPMUX_A_PC;
    else if (w_wb_a)  bus.sel_a = CORE_OPMUX_A_WB;
  end

  always_comb begin
    bus.sel_b = CORE_OPMUX_B_RB;
    unique case (bus.id_b_src)
      B_SRC_PC:   bus.sel_b = CORE_OPMUX_B_PC;
      B_SRC_IMM:  bus.sel_b = CORE_OPMUX_B_IMM;
      B_SRC_NONE: bus.sel_b = CORE_OPMUX_B_RB;
      default:    bus.sel_b = w_wb_b ? CORE_OPMUX_B_WB : CORE_OPMUX_B_RB;
    endcase
  end

  assign bus.stall     = w_stall;
  assign bus.issue     = w_issue;
  assign bus.stall_cnt = r_cnt;

  // Scoreboard shift; non-issuing cycles enter as bubbles, flush empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_v  <= '0;
      r_sb_rd <= '0;
    end else if (bus.flush) begin
      r_sb_v  <= '0;
    end else begin
      r_sb_v  <= {r_sb_v[1:0], w_issue & bus.id_wr & (bus.id_rd != '0)};
      r_sb_rd <= {r_sb_rd[1:0], bus.id_rd};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Debug-only state; mirrors whether ID is currently held
  always_comb begin
    w_fsm_d = r_fsm;
    unique case (r_fsm)
      StRun:   if (w_stall) w_fsm_d = StStall;
      StStall: if (bus.flush || !w_stall) w_fsm_d = StRun;
      default: w_fsm_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= StRun;
    else     r_fsm <= w_fsm_d;
  end

endmodule
